// File: rtl/scan_responder.sv
// scan_responder: serial scan-chain responder that captures the core image, shifts a frame and commits it back
// Optional frame length checking: define SCAN_FRAME_CHECK_EN.
// Ports:
//   clk_in, rst_in (sync, active-low)
//   scan_enable_in, scan_in, scan_out    : serial frame interface, MSB first
//   halt_in                              : core halt flag, shown on scan_out between frames
//   core_image_in                        : live parallel core image
//   commit_data_out, commit_valid_out    : image to write into the core, qualified by valid
//   commit_ready_in                      : core accepts the commit
//   frame_err_out                        : sticky, last frame had the wrong bit count
//   busy_out                             : high in any state except IDLE
module scan_responder #(
  parameter int FULL_MEM_SIZE = 18,
  localparam int SCAN_CHAIN_SIZE = 24 + 8 * FULL_MEM_SIZE
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       scan_enable_in,
  input  logic                       scan_in,
  output logic                       scan_out,
  input  logic                       halt_in,
  input  logic [SCAN_CHAIN_SIZE-1:0] core_image_in,
  output logic [SCAN_CHAIN_SIZE-1:0] commit_data_out,
  output logic                       commit_valid_out,
  input  logic                       commit_ready_in,
  output logic                       frame_err_out,
  output logic                       busy_out
);
  localparam int N = SCAN_CHAIN_SIZE;
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
  state_t state, nxt;
  logic [N-1:0] shreg;
  logic len_ok;
  always_ff @(posedge clk_in)
    state <= !rst_in ? IDLE : nxt;
  always_comb begin
    nxt = state;
    if (state == IDLE) nxt = scan_enable_in ? SHIFT : IDLE;
    if (state == SHIFT && !scan_enable_in) nxt = len_ok ? COMMIT : IDLE;
    if (state == COMMIT && commit_ready_in) nxt = IDLE;
  end
  // The first shift edge captures the live image, so the frame shifts the image out while shifting the new one in.
  always_ff @(posedge clk_in)
    if (!rst_in) shreg <= '0;
    else if (scan_enable_in && state == IDLE) shreg <= {core_image_in[N-2:0], scan_in};
    else if (scan_enable_in && state == SHIFT) shreg <= {shreg[N-2:0], scan_in};
`ifdef SCAN_FRAME_CHECK_EN
  localparam int CW = $clog2(N + 2);
  logic [CW-1:0] bitcnt;
  logic frame_err;
  always_ff @(posedge clk_in)
    if (!rst_in) begin
      bitcnt <= '0;
      frame_err <= 1'b0;
    end else begin
      if (scan_enable_in && state == IDLE) bitcnt <= CW'(1);
      else if (scan_enable_in && state == SHIFT && bitcnt != CW'(N + 1)) bitcnt <= bitcnt + 1'b1;
      if (!scan_enable_in && state == SHIFT) frame_err <= !len_ok;
    end
  assign len_ok = bitcnt == CW'(N);
  assign frame_err_out = frame_err;
`else
  assign len_ok = 1'b1;
  assign frame_err_out = 1'b0;
`endif
  assign scan_out = !scan_enable_in ? halt_in : (state == IDLE ? core_image_in[N-1] : shreg[N-1]);
  assign commit_data_out = shreg;
  assign commit_valid_out = state == COMMIT;
  assign busy_out = state != IDLE;
endmodule

// File: doc/scan_responder.md
SCAN_RESPONDER -- requirements
Module: scan_responder

Interface
REQ-001 SHALL have parameter FULL_MEM_SIZE, default 18, number of 8-bit memory cells in the chain (IO register included).
REQ-002 SHALL have localparam SCAN_CHAIN_SIZE = 24 + 8*FULL_MEM_SIZE (168 at default); it is not overridable.
REQ-003 SHALL have port clk_in, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_in, input, 1, reset: one clock, reset synchronous and active-low.
REQ-005 SHALL have port scan_enable_in, input, 1, active-high frame enable, already de-inverted from the pin.
REQ-006 SHALL have port scan_in, input, 1, serial data in, MSB of image first.
REQ-007 SHALL have port scan_out, output, 1, serial data out, MSB of image first; halt status outside frames.
REQ-008 SHALL have port halt_in, input, 1, core halt flag.
REQ-009 SHALL have port core_image_in, input, SCAN_CHAIN_SIZE, live parallel core image: [2:0] state, [7:3] PC, [15:8] IR, [23:16] ACC, then MEM[k] at [31+8k -: 8].
REQ-010 SHALL have port commit_data_out, output, SCAN_CHAIN_SIZE, image to write into the core.
REQ-011 SHALL have port commit_valid_out, output, 1, commit request; port commit_ready_in, input, 1, core accepts.
REQ-012 SHALL have port frame_err_out, output, 1, sticky flag: last frame had the wrong bit count.
REQ-013 SHALL have port busy_out, output, 1, high in any state except IDLE.

Function
REQ-014 SHALL implement states IDLE, SHIFT, COMMIT.
REQ-015 In IDLE with scan_enable_in=1 at an edge, SHALL load shreg <= {core_image_in[N-2:0], scan_in}, set bitcnt to 1 and enter SHIFT.
REQ-016 In SHIFT with scan_enable_in=1, SHALL load shreg <= {shreg[N-2:0], scan_in} and bitcnt <= bitcnt+1; bitcnt saturates at N+1.
REQ-017 scan_out SHALL be combinational: halt_in when scan_enable_in=0; core_image_in[N-1] in IDLE with scan_enable_in=1; shreg[N-1] in SHIFT.
REQ-018 In SHIFT with scan_enable_in=0: if bitcnt==N, SHALL clear frame_err_out and enter COMMIT; otherwise SHALL set frame_err_out and return to IDLE without committing.
REQ-019 In COMMIT, commit_valid_out SHALL be 1 and commit_data_out SHALL equal shreg, both held stable until an edge where commit_ready_in=1; that edge SHALL return to IDLE.
REQ-020 commit_valid_out SHALL rise one cycle after the falling scan_enable_in edge when commit_ready_in is constantly 1, so commit latency is 1 cycle.
REQ-021 scan_enable_in=1 during COMMIT SHALL NOT shift shreg. If it is still high on return to IDLE, a new frame starts then; the bits already missed make that frame short, so it flags an error.
REQ-022 commit_data_out SHALL equal shreg in every state; only commit_valid_out qualifies it.
REQ-023 An N-bit frame SHALL leave the chip image unchanged at commit when scan_in is looped back from scan_out.

Reset
REQ-024 With rst_in=0 at an edge: state=IDLE, shreg=0, bitcnt=0, commit_valid_out=0, frame_err_out=0, busy_out=0.
REQ-025 Reset SHALL abort SHIFT or COMMIT immediately with no commit; during reset scan_out still follows REQ-017.

Configuration
REQ-026 Macro SCAN_FRAME_CHECK_EN defined: bitcnt and frame_err_out behave as in REQ-016/018.
REQ-027 Macro SCAN_FRAME_CHECK_EN undefined: no bit counter; every SHIFT->IDLE exit enters COMMIT regardless of length; frame_err_out is tied 0.

Verification
REQ-028 Reset, core_image_in MEM[0]=E0, MEM[1]=E1, ACC=01, PC=1, state=001; 168-bit frame shifting in all-zero -> scan_out stream equals core_image_in MSB-first; commit_data_out=0; commit_valid_out high 1 cycle after enable drop.
REQ-029 168-bit frame with [2:0]=001, [7:3]=1, [15:8]=E0, [31:24]=E0, [167:160]=F0; commit_ready_in=0 for 3 cycles then 1 -> valid held 4 cycles, data stable, then IDLE.
REQ-030 167-bit frame -> frame_err_out=1, no commit_valid_out; next 168-bit frame -> frame_err_out=0 and commit occurs.
REQ-031 200-bit frame -> frame_err_out=1 (counter saturated), no commit; with SCAN_FRAME_CHECK_EN undefined the same frame commits its last 168 bits.
REQ-032 Scan disabled, halt_in toggling 0/1 -> scan_out follows it; rst_in=0 asserted at bit 80 of a frame -> IDLE, no commit, busy_out=0 next cycle.
